// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-free shifter: applies a single-position shift once per cycle
// until the requested count is exhausted, then publishes the result for one DONE cycle.

module shift_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    case (op)
      2'b00:   shifted = value;
      2'b01:   shifted = {value[WIDTH-2:0], 1'b0};
      2'b10:   shifted = {1'b0, value[WIDTH-1:1]};
      default: shifted = {value[WIDTH-1], value[WIDTH-1:1]};
    endcase
  end

endmodule

module shift_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic [3:0]       amount,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] next_work;
  logic [WIDTH-1:0] step_out;
  logic [3:0]       count;
  logic [3:0]       next_count;
  logic [1:0]       op_q;
  logic [1:0]       next_op;
  logic             load_result;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value   (work),
    .op      (op_q),
    .shifted (step_out)
  );

  // result is captured from the value the working register takes on DONE entry
  always_comb begin
    next_state  = state;
    next_work   = work;
    next_count  = count;
    next_op     = op_q;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_work  = in;
          next_op    = op;
          next_count = amount;
          if (amount == 4'd0) begin
            next_state  = DONE;
            load_result = 1'b1;
          end else begin
            next_state = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          next_work  = step_out;
          next_count = count - 4'd1;
          if (count == 4'd1) begin
            next_state  = DONE;
            load_result = 1'b1;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      count  <= '0;
      op_q   <= '0;
      result <= '0;
    end else begin
      state <= next_state;
      work  <= next_work;
      count <= next_count;
      op_q  <= next_op;
      if (load_result) begin
        result <= next_work;
      end
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// run, all compared every cycle against a cycle-count/arithmetic reference model.

module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in_v = '0;
  logic [1:0]  op_v = '0;
  logic [3:0]  amt_v = '0;
  logic        abort = 1'b0;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int passes = 0;
  bit check_en = 1'b0;

  // reference model: cycles elapsed since acceptance and the arithmetic answer
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_amt = 0;
  logic [15:0] m_exp = '0;
  logic [15:0] m_result = '0;

  shift_sequencer #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in     (in_v),
    .op     (op_v),
    .amount (amt_v),
    .abort  (abort),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [1:0] o,
                                            input int a);
    logic [15:0] r;
    case (o)
      2'b00:   r = v;
      2'b01:   r = v << a;
      2'b10:   r = v >> a;
      default: r = $unsigned($signed(v) >>> a);
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_result = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_k      = 1;
        m_amt    = int'(amt_v);
        m_exp    = ref_shift(in_v, op_v, int'(amt_v));
        if (m_k == m_amt + 1) m_result = m_exp;
      end
    end else if (m_k == m_amt + 1) begin
      m_active = 1'b0;
    end else if (abort) begin
      m_active = 1'b0;
    end else begin
      m_k = m_k + 1;
      if (m_k == m_amt + 1) m_result = m_exp;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cyc_ready", 32'(ready), 32'(!m_active));
      checkOutput("cyc_busy", 32'(busy), 32'(m_active && m_k <= m_amt));
      checkOutput("cyc_done", 32'(done), 32'(m_active && m_k == m_amt + 1));
      checkOutput("cyc_result", 32'(result), 32'(m_result));
    end
  end

  // drive a one-cycle start pulse; returns at the negedge after the accepting edge
  task automatic applyStimulus(input logic [15:0] i, input logic [1:0] o, input logic [3:0] a);
    in_v  = i;
    op_v  = o;
    amt_v = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int lat0, output int lat, output int busy_cnt);
    lat      = lat0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input string name, input logic [15:0] i, input logic [1:0] o,
                       input logic [3:0] a, input logic [15:0] want);
    int lat;
    int bc;
    applyStimulus(i, o, a);
    waitDone(1, lat, bc);
    checkOutput({name, "_latency"}, 32'(lat), 32'(a) + 32'd1);
    checkOutput({name, "_busy_cycles"}, 32'(bc), 32'(a));
    checkOutput({name, "_result"}, 32'(result), 32'(want));
    checkOutput({name, "_model"}, 32'(m_result), 32'(want));
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int bc;
    int late;

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_en = 1'b1;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", 32'(result), 32'h0);

    runOp("left4", 16'h00F1, 2'b01, 4'd4, 16'h0F10);
    runOp("arith15", 16'h8001, 2'b11, 4'd15, 16'hFFFF);
    runOp("logic15", 16'h8001, 2'b10, 4'd15, 16'h0001);
    runOp("zero_amt", 16'hF0F0, 2'b10, 4'd0, 16'hF0F0);
    runOp("pass7", 16'hBEEF, 2'b00, 4'd7, 16'hBEEF);

    applyStimulus(16'h1234, 2'b01, 4'd8);
    in_v  = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(2, lat, bc);
    checkOutput("restart_latency", 32'(lat), 32'd9);
    checkOutput("restart_result", 32'(result), 32'h3400);
    @(negedge clk);

    runOp("left1", 16'h0001, 2'b01, 4'd1, 16'h0002);
    applyStimulus(16'h0101, 2'b01, 4'd6);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", 32'(result), 32'h0002);

    applyStimulus(16'h5555, 2'b10, 4'd10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_ready", 32'(ready), 32'd1);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_result", 32'(result), 32'h0);
    late = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) late++;
      @(negedge clk);
    end
    checkOutput("midreset_no_late_done", 32'(late), 32'd0);

    for (int c = 0; c < 2000; c++) begin
      in_v  = 16'($urandom);
      op_v  = 2'($urandom);
      amt_v = 4'($urandom);
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 14) == 0);
      reset = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
